// File: rtl/dec_to_bin_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package dec_to_bin_pkg;

    localparam int unsigned DEFAULT_DIGITS = 8;
    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned CORR_THRESH    = 8;
    localparam int unsigned CORR_SUB       = 3;
    localparam int unsigned ILLEGAL_MIN    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/dec_to_bin_dabble_step.sv
// One reverse double-dabble step: shift {S,B} right by one, then subtract 3
// from every BCD digit of S that is >= 8.
// Ports:
//   sb_i  {S,B} before the step (S in the upper W bits)
//   sb_o  {S,B} after the shift and per-digit correction
module dabble_step
    import dec_to_bin_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
    input  logic [2*DIGIT_W*DIGITS-1:0] sb_i,
    output logic [2*DIGIT_W*DIGITS-1:0] sb_o
);

    localparam int unsigned W = DIGIT_W * DIGITS;

    logic [2*W-1:0] shifted;

    assign shifted      = sb_i >> 1;
    assign sb_o[W-1:0]  = shifted[W-1:0];

    // Per-digit correction; digits are independent (no borrow between them).
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [DIGIT_W-1:0] dig;
        assign dig = shifted[W + DIGIT_W*k +: DIGIT_W];
        assign sb_o[W + DIGIT_W*k +: DIGIT_W] =
            (dig >= DIGIT_W'(CORR_THRESH)) ? dig - DIGIT_W'(CORR_SUB) : dig;
    end

endmodule

// File: rtl/dec_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble) with a
// start/busy/done handshake.
// Optional build macro: DEC_TO_BIN_DUAL_SHIFT_EN -- two chained dabble steps
// per SHIFT cycle, halving conversion latency.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   start   conversion request, sampled only in IDLE
//   bcd     packed BCD digits, ten_k at bcd[4k+3:4k]
//   busy    high while a conversion is in progress
//   done    one-cycle pulse when binary/error are updated
//   error   last request contained a digit > 9
//   binary  zero-extended result, held between done pulses
module dec_to_bin
    import dec_to_bin_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DIGIT_W*DIGITS-1:0]  bcd,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [DIGIT_W*DIGITS-1:0]  binary
);

    localparam int unsigned W = DIGIT_W * DIGITS;
`ifdef DEC_TO_BIN_DUAL_SHIFT_EN
    localparam int unsigned STEPS = W / 2;
`else
    localparam int unsigned STEPS = W;
`endif
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_e             state_q, state_d;
    logic [W-1:0]       s_q, s_d;
    logic [W-1:0]       b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [W-1:0]       binary_q, binary_d;

    logic [DIGITS-1:0]  dig_bad;
    logic [2*W-1:0]     step_out;

    // Flag any input digit outside 0..9.
    for (genvar k = 0; k < DIGITS; k++) begin : g_check
        assign dig_bad[k] = (bcd[DIGIT_W*k +: DIGIT_W] >= DIGIT_W'(ILLEGAL_MIN));
    end

    // Shift/correct datapath: one step, or two chained steps per cycle.
`ifdef DEC_TO_BIN_DUAL_SHIFT_EN
    logic [2*W-1:0] step_mid;

    dabble_step #(.DIGITS(DIGITS)) u_step0 (
        .sb_i ({s_q, b_q}),
        .sb_o (step_mid)
    );

    dabble_step #(.DIGITS(DIGITS)) u_step1 (
        .sb_i (step_mid),
        .sb_o (step_out)
    );
`else
    dabble_step #(.DIGITS(DIGITS)) u_step0 (
        .sb_i ({s_q, b_q}),
        .sb_o (step_out)
    );
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            binary_q <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            binary_q <= binary_d;
        end
    end

    // Next-state and output logic. done/binary/error are registered on the
    // edge entering FINISH so they are all visible during the FINISH cycle.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        binary_d = binary_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (|dig_bad) begin
                        state_d  = FINISH;
                        b_d      = '0;
                        error_d  = 1'b1;
                        binary_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        state_d  = SHIFT;
                        s_d      = bcd;
                        b_d      = '0;
                        cnt_d    = '0;
                        error_d  = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                s_d   = step_out[2*W-1:W];
                b_d   = step_out[W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d  = FINISH;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    binary_d = step_out[W-1:0];
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign binary = binary_q;

endmodule

// File: tb/tb_dec_to_bin.sv
// Self-checking bench for dec_to_bin: directed vectors plus random legal BCD.
module tb_dec_to_bin;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned W      = 4 * DIGITS;
`ifdef DEC_TO_BIN_DUAL_SHIFT_EN
    localparam int LAT = W / 2 + 1;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] bcd;
    logic         busy;
    logic         done;
    logic         error;
    logic [W-1:0] binary;

    int checks;
    int errors;

    dec_to_bin #(.DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bcd    (bcd),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .binary (binary)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic do_start(input logic [W-1:0] val);
        @(negedge clk);
        bcd   = val;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges from the accepting edge (counted as 1) until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bcd   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error, binary} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b error=%b binary=%h, want 0/0/0/00000000",
                     busy, done, error, binary);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, error, binary} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL idle_outputs: got busy=%b done=%b error=%b binary=%h, want all 0",
                     busy, done, error, binary);
        end
    endtask

    task automatic test_legal(input logic [W-1:0] val, input logic [W-1:0] exp);
        int lat;
        do_start(val);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start(%h): got %b, want 1", val, busy);
        end
        wait_done(lat);
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency(%h): got %0d, want %0d", val, lat, LAT);
        end
        checks++;
        if (binary !== exp || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL result(%h): got binary=%h error=%b busy=%b, want %h 0 0",
                     val, binary, error, busy, exp);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width(%h): got done=%b one cycle later, want 0", val, done);
        end
    endtask

    task automatic test_illegal();
        int lat;
        do_start(32'h0000A123);
        wait_done(lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL illegal_latency: got %0d, want 1", lat);
        end
        checks++;
        if (error !== 1'b1 || binary !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_result: got error=%b binary=%h busy=%b, want 1 00000000 0",
                     error, binary, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold: got error=%b done=%b, want 1 0", error, done);
        end
        test_legal(32'h00000042, 32'h0000002A);
    endtask

    // Extra start pulses while busy and during FINISH must be ignored.
    task automatic test_ignored_start();
        int dones;
        int done_at;
        dones   = 0;
        done_at = -1;
        do_start(32'h00000100);
        bcd = 32'h99999999;
        for (int t = 1; t <= LAT + 12; t++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                done_at = t;
            end
            start = (t == 4 || t == LAT - 1) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || done_at != LAT - 1) begin
            errors++;
            $display("FAIL ignored_start_dones: got %0d done(s), last at edge %0d, want 1 at %0d",
                     dones, done_at, LAT - 1);
        end
        checks++;
        if (binary !== 32'h00000064 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_result: got binary=%h busy=%b, want 00000064 0", binary, busy);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        test_legal(32'h00000042, 32'h0000002A);
        do_start(32'h87654321);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, binary} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b error=%b binary=%h, want all 0",
                     busy, done, error, binary);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < LAT + 4; t++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d cycles with busy/done, want 0", dones);
        end
        test_legal(32'h87654321, 32'h05397FB1);
    endtask

    // Random legal values against decimal arithmetic; result must hold while idle.
    task automatic test_random();
        logic [W-1:0] val;
        logic [W-1:0] exp;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            int unsigned acc;
            int unsigned pw;
            acc = 0;
            pw  = 1;
            for (int k = 0; k < DIGITS; k++) begin
                int unsigned d;
                d = $urandom_range(9, 0);
                val[4*k +: 4] = 4'(d);
                acc = acc + d * pw;
                pw  = pw * 10;
            end
            exp = acc;
            do_start(val);
            wait_done(lat);
            checks++;
            if (lat != LAT || binary !== exp || error !== 1'b0) begin
                errors++;
                $display("FAIL random(%h): got binary=%h lat=%0d error=%b, want %h lat=%0d error=0",
                         val, binary, lat, error, exp, LAT);
            end
            bcd = ~val;
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (binary !== exp || done !== 1'b0) begin
                errors++;
                $display("FAIL random_hold(%h): got binary=%h done=%b, want %h 0", val, binary, done, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_legal(32'h00000000, 32'h00000000);
        test_legal(32'h12345678, 32'h00BC614E);
        test_legal(32'h99999999, 32'h05F5E0FF);
        test_illegal();
        test_ignored_start();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
